// File: rtl/cam_downsampler_p_if.sv
// rtl/cam_downsampler_p_if.sv - camera byte stream in, framebuffer write port out
interface cam_downsampler_p_if;
    logic       HREF;
    logic       VSYNC;
    logic [7:0] pixel_in;
    logic [7:0] pixel_out;
    logic       W_EN;
    logic [7:0] X_ADDR;
    logic [7:0] Y_ADDR;
    logic       FRAME_DONE;
    logic       LINE_ERR;

    modport master (
        output HREF, VSYNC, pixel_in,
        input  pixel_out, W_EN, X_ADDR, Y_ADDR, FRAME_DONE, LINE_ERR
    );

    modport slave (
        input  HREF, VSYNC, pixel_in,
        output pixel_out, W_EN, X_ADDR, Y_ADDR, FRAME_DONE, LINE_ERR
    );
endinterface

// File: rtl/cam_downsampler_p.sv
// rtl/cam_downsampler_p.sv - camera byte-pair to 8-bit pixel converter with decimating framebuffer writer
module cam_downsampler_p #(
    parameter int IN_FMT  = 0,
    parameter int DECIM   = 1,
    parameter int H_PIX   = 176,
    parameter int V_LINES = 144
) (
    input  logic PCLK,
    input  logic RESET,
    cam_downsampler_p_if.slave cam
);
    localparam int CW = 11;
    localparam int SH = (DECIM == 4) ? 2 : ((DECIM == 2) ? 1 : 0);
    localparam logic [CW-1:0] CMAX  = '1;
    localparam logic [CW-1:0] DMASK = CW'(DECIM - 1);

    logic          phase;
    logic          href_d;
    logic          vsync_d;
    logic          line_ok;
    logic          written;
    logic [7:0]    b0;
    logic [CW-1:0] xc;
    logic [CW-1:0] yc;
    logic [CW-1:0] xq;
    logic [CW-1:0] yq;
    logic [7:0]    pix_conv;
    logic          href_fall;
    logic          vs_rise;
    logic          odd_fall;
    logic          take_pixel;
    logic          do_write;

    always_comb begin
        href_fall  = href_d & ~cam.HREF;
        vs_rise    = cam.VSYNC & ~vsync_d;
        odd_fall   = href_fall & phase;
        take_pixel = cam.HREF & ~cam.VSYNC & phase;
        xq         = xc >> SH;
        yq         = yc >> SH;
        // line_ok is low for a line cut by reset or VSYNC, so its tail never lands in memory
        do_write   = take_pixel & line_ok
                   & ((xc & DMASK) == '0) & ((yc & DMASK) == '0)
                   & (xq < CW'(H_PIX)) & (yq < CW'(V_LINES));
        pix_conv   = b0;
        if (IN_FMT == 0)
            pix_conv = {b0[7:5], b0[2:0], cam.pixel_in[4:3]};
        else if (IN_FMT == 1)
            pix_conv = {b0[3:1], cam.pixel_in[7:5], cam.pixel_in[3:2]};
    end

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            phase          <= 1'b0;
            href_d         <= 1'b0;
            vsync_d        <= 1'b0;
            line_ok        <= 1'b0;
            written        <= 1'b0;
            b0             <= '0;
            xc             <= '0;
            yc             <= '0;
            cam.pixel_out  <= '0;
            cam.W_EN       <= 1'b0;
            cam.X_ADDR     <= '0;
            cam.Y_ADDR     <= '0;
            cam.FRAME_DONE <= 1'b0;
            cam.LINE_ERR   <= 1'b0;
        end else begin
            href_d  <= cam.HREF;
            vsync_d <= cam.VSYNC;
            phase   <= (cam.HREF && !cam.VSYNC) ? ~phase : 1'b0;
            if (cam.HREF && !cam.VSYNC && !phase)
                b0 <= cam.pixel_in;

            if (!cam.HREF)
                line_ok <= 1'b1;
            else if (cam.VSYNC)
                line_ok <= 1'b0;

            if (!cam.HREF || cam.VSYNC)
                xc <= '0;
            else if (take_pixel && xc != CMAX)
                xc <= xc + 1'b1;

            if (cam.VSYNC)
                yc <= '0;
            else if (href_fall && line_ok && yc != CMAX)
                yc <= yc + 1'b1;

            cam.W_EN <= do_write;
            if (do_write) begin
                cam.pixel_out <= pix_conv;
                cam.X_ADDR    <= xq[7:0];
                cam.Y_ADDR    <= yq[7:0];
            end

            if (do_write)
                written <= 1'b1;
            else if (vs_rise)
                written <= 1'b0;
            cam.FRAME_DONE <= vs_rise & written;

            // an odd fall on the same edge as the VSYNC rise keeps the flag set
            if (vs_rise)
                cam.LINE_ERR <= odd_fall;
            else if (odd_fall)
                cam.LINE_ERR <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cam_downsampler_p.sv
// tb/tb_cam_downsampler_p.sv - three-configuration bench for cam_downsampler_p against a byte-count model
module tb_cam_downsampler_p;
    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       href = 1'b0;
    logic       vsync = 1'b0;
    logic [7:0] pin = '0;

    always #5 pclk = ~pclk;

    cam_downsampler_p_if if0 ();
    cam_downsampler_p_if if1 ();
    cam_downsampler_p_if if2 ();

    assign if0.HREF = href;  assign if0.VSYNC = vsync;  assign if0.pixel_in = pin;
    assign if1.HREF = href;  assign if1.VSYNC = vsync;  assign if1.pixel_in = pin;
    assign if2.HREF = href;  assign if2.VSYNC = vsync;  assign if2.pixel_in = pin;

    cam_downsampler_p #(.IN_FMT(0), .DECIM(1), .H_PIX(4),   .V_LINES(3))
        u0 (.PCLK(pclk), .RESET(rst), .cam(if0));
    cam_downsampler_p #(.IN_FMT(1), .DECIM(4), .H_PIX(5),   .V_LINES(3))
        u1 (.PCLK(pclk), .RESET(rst), .cam(if1));
    cam_downsampler_p #(.IN_FMT(2), .DECIM(2), .H_PIX(176), .V_LINES(144))
        u2 (.PCLK(pclk), .RESET(rst), .cam(if2));

    logic       o_wen [3];
    logic [7:0] o_pix [3];
    logic [7:0] o_x   [3];
    logic [7:0] o_y   [3];
    logic       o_fd  [3];
    logic       o_le  [3];

    assign o_wen[0] = if0.W_EN; assign o_pix[0] = if0.pixel_out; assign o_x[0] = if0.X_ADDR;
    assign o_y[0] = if0.Y_ADDR; assign o_fd[0] = if0.FRAME_DONE; assign o_le[0] = if0.LINE_ERR;
    assign o_wen[1] = if1.W_EN; assign o_pix[1] = if1.pixel_out; assign o_x[1] = if1.X_ADDR;
    assign o_y[1] = if1.Y_ADDR; assign o_fd[1] = if1.FRAME_DONE; assign o_le[1] = if1.LINE_ERR;
    assign o_wen[2] = if2.W_EN; assign o_pix[2] = if2.pixel_out; assign o_x[2] = if2.X_ADDR;
    assign o_y[2] = if2.Y_ADDR; assign o_fd[2] = if2.FRAME_DONE; assign o_le[2] = if2.LINE_ERR;

    int fmt [3] = '{0, 1, 2};
    int dec [3] = '{1, 4, 2};
    int hp  [3] = '{4, 5, 176};
    int vl  [3] = '{3, 3, 144};

    // model state: bytes seen in the current clean run, completed lines since VSYNC
    int         run_bytes;
    bit         run_ok;
    int         line_no;
    bit         hprev, vprev;
    logic [7:0] mb0;
    bit         written [3];
    logic       e_wen [3];
    logic [7:0] e_pix [3];
    logic [7:0] e_x   [3];
    logic [7:0] e_y   [3];
    logic       e_fd  [3];
    logic       e_le;

    int total = 0;
    int bad = 0;
    int wcount [3] = '{0, 0, 0};
    int fdcount [3] = '{0, 0, 0};
    logic [15:0] log2 [$];

    function automatic logic [7:0] conv(input int f, input logic [7:0] a, input logic [7:0] b);
        int ia, ib;
        ia = int'(a);
        ib = int'(b);
        if (f == 0) return 8'((ia / 32) * 32 + (ia % 8) * 4 + (ib / 8) % 4);
        if (f == 1) return 8'(((ia / 2) % 8) * 32 + (ib / 32) * 4 + (ib / 4) % 4);
        return a;
    endfunction

    task automatic model_step(input logic h, input logic v, input logic [7:0] d, input logic r);
        bit vs_rise, h_fall, odd_fall;
        int idx;
        if (r) begin
            run_bytes = 0; run_ok = 0; line_no = 0; hprev = 0; vprev = 0; mb0 = '0; e_le = 0;
            for (int i = 0; i < 3; i++) begin
                written[i] = 0; e_wen[i] = 0; e_pix[i] = '0; e_x[i] = '0; e_y[i] = '0; e_fd[i] = 0;
            end
            return;
        end
        vs_rise  = v && !vprev;
        h_fall   = hprev && !h;
        odd_fall = h_fall && (run_bytes % 2 == 1);
        for (int i = 0; i < 3; i++) begin
            e_wen[i] = 0;
            e_fd[i]  = 0;
        end
        if (vs_rise) begin
            for (int i = 0; i < 3; i++) begin
                e_fd[i] = written[i];
                written[i] = 0;
            end
            e_le = odd_fall;
        end else if (odd_fall) begin
            e_le = 1;
        end
        if (h && !v) begin
            if (run_bytes % 2 == 0) begin
                mb0 = d;
            end else begin
                idx = run_bytes / 2;
                for (int i = 0; i < 3; i++) begin
                    if (run_ok && idx % dec[i] == 0 && line_no % dec[i] == 0 &&
                        idx / dec[i] < hp[i] && line_no / dec[i] < vl[i]) begin
                        e_wen[i]   = 1;
                        e_pix[i]   = conv(fmt[i], mb0, d);
                        e_x[i]     = 8'(idx / dec[i]);
                        e_y[i]     = 8'(line_no / dec[i]);
                        written[i] = 1;
                    end
                end
            end
            run_bytes++;
        end else begin
            run_bytes = 0;
        end
        if (v) line_no = 0;
        else if (h_fall && run_ok) line_no++;
        if (!h) run_ok = 1;
        else if (v) run_ok = 0;
        hprev = h;
        vprev = v;
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (o_wen[i] !== e_wen[i] || o_fd[i] !== e_fd[i] || o_le[i] !== e_le ||
                o_pix[i] !== e_pix[i] || o_x[i] !== e_x[i] || o_y[i] !== e_y[i]) begin
                bad++;
                $display("FAIL out%0d t=%0t got wen=%b pix=%h x=%0d y=%0d fd=%b le=%b want wen=%b pix=%h x=%0d y=%0d fd=%b le=%b",
                         i, $time, o_wen[i], o_pix[i], o_x[i], o_y[i], o_fd[i], o_le[i],
                         e_wen[i], e_pix[i], e_x[i], e_y[i], e_fd[i], e_le);
            end
            if (o_wen[i] === 1'b1) wcount[i]++;
            if (o_fd[i] === 1'b1) fdcount[i]++;
            if (i == 2 && o_wen[i] === 1'b1) log2.push_back({o_x[i], o_pix[i]});
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic h, input logic v, input logic [7:0] d, input logic r);
        href = h; vsync = v; pin = d; rst = r;
        model_step(h, v, d, r);
        @(posedge pclk);
        #1;
        check_all();
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic vs(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
    endtask

    // mode 1 puts luma 0x10,0x20.. on even bytes
    task automatic send_line(input int nbytes, input int mode);
        logic [7:0] b;
        for (int k = 0; k < nbytes; k++) begin
            b = 8'($urandom);
            if (mode == 1 && k % 2 == 0) b = 8'(16 * (k / 2 + 1));
            step(1'b1, 1'b0, b, 1'b0);
        end
    endtask

    int w0, w2, f0, f2;

    initial begin
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'h00, 1'b1);
        lit("reset_outputs", {o_wen[0], o_pix[0], o_x[0], o_y[0], o_fd[0], o_le[0]}, 0);
        vs(2);
        gap(3);

        w0 = wcount[0];
        step(1'b1, 1'b0, 8'hF8, 1'b0);
        step(1'b1, 1'b0, 8'h1F, 1'b0);
        lit("first_wen", o_wen[0], 1);
        lit("first_pix", o_pix[0], 8'hE3);
        lit("first_x", o_x[0], 0);
        lit("first_y", o_y[0], 0);
        send_line(10, 0);
        gap(3);
        lit("hclip_writes", wcount[0] - w0, 4);
        f0 = fdcount[0];
        vs(2);
        gap(3);
        lit("frame1_done", fdcount[0] - f0, 1);

        log2.delete();
        send_line(16, 1);
        gap(3);
        lit("luma_count", log2.size(), 4);
        if (log2.size() == 4) begin
            lit("luma_w0", log2[0], 16'h0010);
            lit("luma_w1", log2[1], 16'h0130);
            lit("luma_w2", log2[2], 16'h0250);
            lit("luma_w3", log2[3], 16'h0370);
        end
        w2 = wcount[2];
        send_line(16, 1);
        gap(3);
        lit("luma_row1_writes", wcount[2] - w2, 0);
        f2 = fdcount[2];
        vs(2);
        gap(2);
        lit("frame2_done", fdcount[2] - f2, 1);
        f2 = fdcount[2];
        vs(2);
        gap(2);
        lit("empty_frame_done", fdcount[2] - f2, 0);

        w0 = wcount[0];
        send_line(5, 0);
        gap(3);
        lit("odd_writes", wcount[0] - w0, 2);
        lit("odd_line_err", o_le[0], 1);
        vs(1);
        lit("line_err_clear", o_le[0], 0);
        gap(3);

        step(1'b1, 1'b0, 8'hA5, 1'b0);
        step(1'b1, 1'b0, 8'h3C, 1'b1);
        lit("midline_reset", {o_wen[0], o_pix[0], o_x[0], o_y[0], o_fd[0], o_le[0]}, 0);
        w0 = wcount[0];
        send_line(3, 0);
        gap(2);
        lit("after_reset_no_write", wcount[0] - w0, 0);
        vs(2);
        gap(2);
        step(1'b1, 1'b0, 8'h24, 1'b0);
        step(1'b1, 1'b0, 8'h18, 1'b0);
        lit("fresh_pair_wen", o_wen[0], 1);
        lit("fresh_pair_pix", o_pix[0], 8'h33);
        gap(3);

        for (int f = 0; f < 8; f++) begin
            vs($urandom_range(1, 3));
            gap($urandom_range(1, 3));
            for (int l = 0; l < int'($urandom_range(1, 14)); l++) begin
                send_line($urandom_range(0, 44), 0);
                if ($urandom_range(0, 9) == 0) begin
                    step(1'b1, 1'b1, 8'($urandom), 1'b0);
                    step(1'b1, 1'b1, 8'($urandom), 1'b0);
                    step(1'b0, 1'b1, 8'($urandom), 1'b0);
                    break;
                end
                gap($urandom_range(1, 3));
            end
        end
        vs(2);
        gap(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cam_downsampler_p.md
CAM_DOWNSAMPLER_P -- requirements
Module: cam_downsampler_p

Interface
REQ-001 Parameter IN_FMT, 0, input format: 0=RGB565, 1=RGB444 (xRGB), 2=YUV422 YUYV luma-only.
REQ-002 Parameter DECIM, 1, horizontal and vertical decimation factor; legal values 1, 2, 4.
REQ-003 Parameter H_PIX, 176, output pixels per line; X_ADDR is 8 bits, so H_PIX <= 256.
REQ-004 Parameter V_LINES, 144, output lines per frame; Y_ADDR is 8 bits, so V_LINES <= 256.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-006 PCLK  input  1  camera pixel clock, sole clock; all logic on rising edge.
REQ-007 RESET  input  1  synchronous active-high reset.
REQ-008 HREF  input  1  line-valid; a byte is sampled every PCLK while high.
REQ-009 VSYNC  input  1  frame sync; high = vertical blank.
REQ-010 pixel_in  input  8  camera data byte.
REQ-011 pixel_out  output  8  converted pixel: RGB332 for IN_FMT 0/1, 8-bit grey for IN_FMT 2.
REQ-012 W_EN  output  1  one-cycle write strobe qualifying pixel_out/X_ADDR/Y_ADDR.
REQ-013 X_ADDR  output  8  output column of the current write.
REQ-014 Y_ADDR  output  8  output row of the current write.
REQ-015 FRAME_DONE  output  1  one-cycle pulse at end of frame.
REQ-016 LINE_ERR  output  1  odd byte count seen in the current frame.

Function
REQ-017 Byte phase: 0 on the first byte of each HREF-high run; toggles every PCLK while HREF=1; forced to 0 while HREF=0 or VSYNC=1.
REQ-018 Phase 0 SHALL latch pixel_in as b0; phase 1 SHALL take pixel_in as b1 and form one input pixel.
REQ-019 IN_FMT 0 SHALL give R=b0[7:5], G=b0[2:0], B=b1[4:3]; output {R,G,B}.
REQ-020 IN_FMT 1 SHALL give R=b0[3:1], G=b1[7:5], B=b1[3:2]; output {R,G,B}.
REQ-021 IN_FMT 2 SHALL output b0 (Y byte); b1 (U/V) is discarded.
REQ-022 Column counter xc SHALL count formed input pixels in the line; it clears while HREF=0.
REQ-023 Row counter yc SHALL increment on each HREF falling edge; it clears while VSYNC=1.
REQ-024 A write SHALL occur only when xc%DECIM==0, yc%DECIM==0, xc/DECIM<H_PIX and yc/DECIM<V_LINES; all other pixels are dropped.
REQ-025 On a write, W_EN=1, pixel_out=converted pixel, X_ADDR=xc/DECIM and Y_ADDR=yc/DECIM SHALL be registered outputs valid the cycle after the phase-1 byte is sampled (latency 1 PCLK).
REQ-026 W_EN SHALL be 0 in every other cycle; pixel_out/X_ADDR/Y_ADDR SHALL hold their last values when W_EN=0.
REQ-027 FRAME_DONE SHALL pulse for exactly 1 cycle on each VSYNC rising edge if at least one write occurred since the previous pulse or since reset.
REQ-028 LINE_ERR SHALL set when HREF falls with byte phase 1, i.e. an odd byte count.
REQ-029 LINE_ERR SHALL remain set until the next VSYNC rising edge; on that edge it clears, and a simultaneous odd-count fall takes priority (LINE_ERR stays 1).
REQ-030 A dangling b0 at an HREF fall SHALL be discarded and SHALL NOT produce a write.
REQ-031 VSYNC rising during HREF=1 SHALL abort the line: no further writes until VSYNC falls, then the counters restart from 0.
REQ-032 Counters SHALL saturate at their maximum rather than wrap; clipped pixels never alias to low addresses.

Reset
REQ-033 RESET=1 at a PCLK edge SHALL clear phase, xc, yc, pixel_out, W_EN, X_ADDR, Y_ADDR, FRAME_DONE, LINE_ERR and the written-since flag to 0 on that edge.
REQ-034 Reset mid-line SHALL discard any partial pixel; after release, no write occurs until a fresh HREF rising edge.

Verification
REQ-035 IN_FMT=0, DECIM=1, bytes 0xF8,0x1F -> 1 cycle later W_EN=1, pixel_out=0xE3, X_ADDR=0, Y_ADDR=0.
REQ-036 IN_FMT=2, DECIM=2, line of 8 pixels with Y=0x10,0x20..0x80, row 0 -> writes 0x10,0x30,0x50,0x70 at X=0..3; row 1 -> no writes.
REQ-037 H_PIX=4, DECIM=1, 6-pixel line -> exactly 4 writes at X=0..3; pixels 5-6 are dropped.
REQ-038 HREF high for 5 bytes -> 2 writes, LINE_ERR=1; LINE_ERR clears on the next VSYNC rise.
REQ-039 Full 2-line frame, then VSYNC rises -> FRAME_DONE high for exactly 1 cycle; a second VSYNC with no writes in between -> no pulse.
REQ-040 RESET asserted after a phase-0 byte -> all outputs 0 next cycle; the next write uses a fresh byte pair.
